// File: rtl/dcache_ctrl.sv
// dcache_ctrl: write-back, write-allocate data cache controller sitting between CPU, SRAM array and memory.
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   cpu_addr_i/data_i/MemRead_i/MemWrite_i  CPU request (held while cpu_stall_o is high)
//   cpu_data_o, cpu_stall_o           load data, stall
//   mem_enable_o/write_o/addr_o/data_o  memory request (line-aligned, registered)
//   mem_data_i, mem_ack_i             memory fill data and acknowledge
//   sram_index_o/tag_o/data_o/enable_o/write_o  SRAM array write/lookup port
//   sram_tag_i/data_i/hit_i           SRAM lookup result ({valid, dirty, tag[22:0]}; victim way on a miss)
module dcache_ctrl #(
    parameter int LINE_W      = 256,
    parameter int MEM_LAT_MAX = 31
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [3:0]        sram_index_o,
    output logic [24:0]       sram_tag_o,
    output logic [LINE_W-1:0] sram_data_o,
    output logic              sram_enable_o,
    output logic              sram_write_o,
    input  logic [24:0]       sram_tag_i,
    input  logic [LINE_W-1:0] sram_data_i,
    input  logic              sram_hit_i
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] MISS       = 3'd1;
    localparam logic [2:0] WRITEBACK  = 3'd2;
    localparam logic [2:0] READMISS   = 3'd3;
    localparam logic [2:0] READMISSOK = 3'd4;

    logic [2:0]        state;
    logic              req;
    logic              dirty;
    logic              fill;
    logic [7:0]        bit_off;
    logic [31:0]       read_addr;
    logic [LINE_W-1:0] merged;
    // Byte-lane bits and the verification-only latency bound have no logic to feed.
    logic              unused_bits;

    assign unused_bits   = ^{cpu_addr_i[1:0], MEM_LAT_MAX > 0};
    assign req           = cpu_MemRead_i | cpu_MemWrite_i;
    assign dirty         = sram_tag_i[24] & sram_tag_i[23];
    assign fill          = (state == READMISS) & mem_ack_i;
    assign bit_off       = {cpu_addr_i[4:2], 5'b0};
    assign read_addr     = {cpu_addr_i[31:5], 5'b0};
    assign sram_index_o  = cpu_addr_i[8:5];
    assign sram_enable_o = req;
    assign cpu_data_o    = sram_data_i[bit_off +: 32];
    assign cpu_stall_o   = (state != IDLE) | (req & ~sram_hit_i);
    // A store hit completes in IDLE; a fill lands in the ack cycle of READMISS.
    assign sram_write_o  = ~rst_i & (fill | ((state == IDLE) & cpu_MemWrite_i & sram_hit_i));
    // Fills install clean lines; store hits mark the line dirty.
    assign sram_tag_o    = {1'b1, ~fill, cpu_addr_i[31:9]};
    assign sram_data_o   = fill ? mem_data_i : merged;

    always_comb begin
        merged = sram_data_i;
        merged[bit_off +: 32] = cpu_data_i;
    end

    // Memory request fields are captured when the request is issued, so the
    // enable pulse appears in the first cycle of WRITEBACK/READMISS.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            mem_enable_o <= 1'b0;
            case (state)
                IDLE: state <= (req & ~sram_hit_i) ? MISS : IDLE;
                MISS: begin
                    mem_enable_o <= 1'b1;
                    mem_write_o  <= dirty;
                    mem_addr_o   <= dirty ? {sram_tag_i[22:0], cpu_addr_i[8:5], 5'b0} : read_addr;
                    mem_data_o   <= sram_data_i;
                    state        <= dirty ? WRITEBACK : READMISS;
                end
                WRITEBACK: if (mem_ack_i) begin
                    mem_enable_o <= 1'b1;
                    mem_write_o  <= 1'b0;
                    mem_addr_o   <= read_addr;
                    state        <= READMISS;
                end
                READMISS: state <= mem_ack_i ? READMISSOK : READMISS;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed self-checking bench for dcache_ctrl with a direct-mapped SRAM model.
module tb_dcache_ctrl;
    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [31:0]  cpu_addr_i = '0;
    logic [31:0]  cpu_data_i = '0;
    logic         cpu_MemRead_i = 1'b0;
    logic         cpu_MemWrite_i = 1'b0;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;
    logic [3:0]   sram_index_o;
    logic [24:0]  sram_tag_o;
    logic [255:0] sram_data_o;
    logic         sram_enable_o;
    logic         sram_write_o;
    logic [24:0]  sram_tag_i;
    logic [255:0] sram_data_i;
    logic         sram_hit_i;

    dcache_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_MemRead_i(cpu_MemRead_i), .cpu_MemWrite_i(cpu_MemWrite_i),
        .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .sram_index_o(sram_index_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
        .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
        .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i)
    );

    always #5 clk_i = ~clk_i;

    logic [24:0]  tags [16];
    logic [255:0] lines [16];
    logic         ld_en = 1'b0;
    logic [3:0]   ld_idx = '0;
    logic [24:0]  ld_tag = '0;
    logic [255:0] ld_data = '0;
    int           nwr = 0;

    assign sram_tag_i  = tags[cpu_addr_i[8:5]];
    assign sram_data_i = lines[cpu_addr_i[8:5]];
    assign sram_hit_i  = tags[cpu_addr_i[8:5]][24] && (tags[cpu_addr_i[8:5]][22:0] == cpu_addr_i[31:9]);

    always @(posedge clk_i) begin
        if (ld_en) begin
            tags[ld_idx]  <= ld_tag;
            lines[ld_idx] <= ld_data;
        end else if (sram_write_o) begin
            tags[sram_index_o]  <= sram_tag_o;
            lines[sram_index_o] <= sram_data_o;
            nwr <= nwr + 1;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mk(input logic [31:0] base);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = base + 32'(i);
        return r;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic preload(input logic [3:0] idx, input logic [24:0] tag, input logic [255:0] data);
        ld_en = 1'b1; ld_idx = idx; ld_tag = tag; ld_data = data;
        step();
        ld_en = 1'b0;
    endtask

    task automatic idle_cpu();
        cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
    endtask

    // Results of one miss run
    int           np, nsw, nst, na;
    logic         pw [2];
    logic [31:0]  pa [2];
    logic [255:0] pd [2];
    logic [31:0]  aa [2];
    logic [24:0]  swt [2];
    logic [255:0] swd [2];

    task automatic miss_run(input logic [31:0] a, input logic [31:0] d, input logic wr,
                            input int ack1, input int ack2, input logic [255:0] f1, input logic [255:0] f2);
        bit done = 0;
        np = 0; nsw = 0; nst = 0; na = 0;
        for (int k = 0; k < 80 && !done; k++) begin
            step();
            cpu_addr_i = a; cpu_data_i = d; cpu_MemWrite_i = wr; cpu_MemRead_i = !wr;
            mem_ack_i  = (k == ack1) || (k == ack2);
            mem_data_i = (k == ack1) ? f1 : f2;
            #1;
            if (mem_ack_i) begin
                if (na < 2) aa[na] = mem_addr_o;
                na++;
            end
            if (mem_enable_o) begin
                if (np < 2) begin pw[np] = mem_write_o; pa[np] = mem_addr_o; pd[np] = mem_data_o; end
                np++;
            end
            if (sram_write_o) begin
                if (nsw < 2) begin swt[nsw] = sram_tag_o; swd[nsw] = sram_data_o; end
                nsw++;
            end
            if (cpu_stall_o) nst++; else done = 1;
        end
        mem_ack_i = 1'b0;
        chk("miss_completes", done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] l9, exp_line;
        int nwr0;
        l9 = mk(32'h9000_0000);
        l9[63:32] = 32'hDEAD_BEEF;
        preload(4'd0, {2'b10, 23'h5}, mk(32'h0500_0000));
        preload(4'd3, {2'b11, 23'h1}, mk(32'hB000_0000));
        preload(4'd5, {2'b10, 23'h7}, mk(32'h0700_0000));
        preload(4'd9, {2'b10, 23'h0}, l9);

        // reset holds outputs low even with a store hit presented
        cpu_addr_i = 32'h0000_0124; cpu_data_i = 32'h1234_5678; cpu_MemWrite_i = 1'b1;
        #1;
        chk("rst_sram_write", sram_write_o, 0);
        chk("rst_mem_enable", mem_enable_o, 0);
        chk("rst_mem_write", mem_write_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_data", mem_data_o, 0);
        idle_cpu();
        step();
        rst_i = 1'b0;

        // load hit
        step();
        cpu_addr_i = 32'h0000_0124; cpu_MemRead_i = 1'b1;
        #1;
        chk("hit_ld_data", cpu_data_o, 32'hDEAD_BEEF);
        chk("hit_ld_stall", cpu_stall_o, 0);
        chk("hit_ld_index", sram_index_o, 9);
        chk("hit_ld_enable", sram_enable_o, 1);
        chk("hit_ld_nowrite", sram_write_o, 0);

        // load miss, clean victim, ack 10 cycles after MISS
        step();
        idle_cpu();
        miss_run(32'h0000_0204, 32'h0, 1'b0, 11, -1, mk(32'hA000_0000), '0);
        chk("lm_stall_cycles", nst, 13);
        chk("lm_pulses", np, 1);
        chk("lm_pulse_dir", pw[0], 0);
        chk("lm_pulse_addr", pa[0], 32'h0000_0200);
        chk("lm_addr_at_ack", aa[0], 32'h0000_0200);
        chk("lm_sram_writes", nsw, 1);
        chk("lm_fill_tag", swt[0], {2'b10, 23'h1});
        chk("lm_fill_data", swd[0], mk(32'hA000_0000));
        chk("lm_replay_data", cpu_data_o, 32'hA000_0001);
        idle_cpu();

        // store hit into the freshly filled line
        step();
        cpu_addr_i = 32'h0000_0208; cpu_data_i = 32'h55AA_55AA; cpu_MemWrite_i = 1'b1;
        #1;
        exp_line = mk(32'hA000_0000);
        exp_line[95:64] = 32'h55AA_55AA;
        chk("st_hit_write", sram_write_o, 1);
        chk("st_hit_stall", cpu_stall_o, 0);
        chk("st_hit_tag", sram_tag_o, {2'b11, 23'h1});
        chk("st_hit_data", sram_data_o, exp_line);
        step();
        idle_cpu();
        #1;
        chk("st_hit_one_pulse", sram_write_o, 0);
        cpu_addr_i = 32'h0000_0208; cpu_MemRead_i = 1'b1;
        #1;
        chk("st_readback", cpu_data_o, 32'h55AA_55AA);
        idle_cpu();

        // store miss, dirty victim tag 1 at index 3
        miss_run(32'h0000_0470, 32'hCAFE_F00D, 1'b1, 5, 8, '0, mk(32'hC000_0000));
        exp_line = mk(32'hC000_0000);
        exp_line[159:128] = 32'hCAFE_F00D;
        chk("sm_stall_cycles", nst, 10);
        chk("sm_pulses", np, 2);
        chk("sm_wb_dir", pw[0], 1);
        chk("sm_wb_addr", pa[0], 32'h0000_0260);
        chk("sm_wb_data", pd[0], mk(32'hB000_0000));
        chk("sm_wb_addr_at_ack", aa[0], 32'h0000_0260);
        chk("sm_rd_dir", pw[1], 0);
        chk("sm_rd_addr", pa[1], 32'h0000_0460);
        chk("sm_rd_addr_at_ack", aa[1], 32'h0000_0460);
        chk("sm_sram_writes", nsw, 2);
        chk("sm_fill_tag", swt[0], {2'b10, 23'h2});
        chk("sm_fill_data", swd[0], mk(32'hC000_0000));
        chk("sm_replay_tag", swt[1], {2'b11, 23'h2});
        chk("sm_replay_data", swd[1], exp_line);
        step();
        idle_cpu();

        // reset in READMISS, stale ack 2 cycles after release
        step();
        cpu_addr_i = 32'h0000_10A0; cpu_MemRead_i = 1'b1;
        step();
        step();
        #1;
        chk("rs_read_pulse", mem_enable_o, 1);
        chk("rs_read_addr", mem_addr_o, 32'h0000_10A0);
        step();
        nwr0 = nwr;
        rst_i = 1'b1;
        idle_cpu();
        #1;
        chk("rs_mem_enable", mem_enable_o, 0);
        chk("rs_mem_addr", mem_addr_o, 0);
        chk("rs_stall", cpu_stall_o, 0);
        step();
        step();
        rst_i = 1'b0;
        step();
        step();
        mem_ack_i = 1'b1; mem_data_i = mk(32'hEEEE_0000);
        #1;
        chk("rs_stale_no_write", sram_write_o, 0);
        chk("rs_stale_no_req", mem_enable_o, 0);
        step();
        mem_ack_i = 1'b0;
        #1;
        chk("rs_idle_stall", cpu_stall_o, 0);
        chk("rs_write_count", nwr - nwr0, 0);
        chk("rs_victim_kept", tags[5], {2'b10, 23'h7});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
